pip_skid_reg: RTL and testbench

- Parametrised pipeline stage register for inter-stage boundaries (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries a WIDTH-bit payload with a valid/ready handshake on each side, plus a synchronous flush for branch/exception squash.
- A 2-entry skid buffer gives full throughput, with every output registered: no combinational path from in_* to out_*, and none from out_ready to in_ready.
- Replaces ad-hoc enable-gated single-bit stage registers; stall is expressed through out_ready back-pressure.

---
 rtl/pip_skid_reg.sv | 76 +++++++
 tb/tb_pip_skid_reg.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/pip_skid_reg.sv
// pip_skid_reg: registered 2-entry skid pipeline stage with valid/ready handshake and flush
// Ports: clk, reset (sync, active-high), flush (sync squash),
//        in_valid/in_ready/in_data (upstream), out_valid/out_ready/out_data (downstream),
//        occupancy (held beats, 0..2). All outputs decode directly from registers.
module pip_skid_reg #(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] BUBBLE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);
  // Encoding equals the beat count, so occupancy is the state register itself.
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;
  state_t           r_state = EMPTY;
  state_t           w_state;
  logic [WIDTH-1:0] r_main = BUBBLE;
  logic [WIDTH-1:0] r_skid = BUBBLE;
  logic [WIDTH-1:0] w_main, w_skid;
  logic             w_acc, w_dq;
  assign in_ready  = r_state != TWO;
  assign out_valid = r_state != EMPTY;
  assign occupancy = r_state;
  assign out_data  = r_main;
  assign w_acc     = in_valid & in_ready;
  assign w_dq      = out_valid & out_ready;
  always_comb begin
    w_state = r_state;
    w_main  = r_main;
    w_skid  = r_skid;
    if (reset) begin
      w_state = EMPTY;
      w_main  = BUBBLE;
      w_skid  = BUBBLE;
    end else if (flush) begin
      // Skid content is left stale; it is unreachable until overwritten in ONE.
      w_state = EMPTY;
      w_main  = BUBBLE;
    end else begin
      case (r_state)
        EMPTY: if (w_acc) begin
          w_state = ONE;
          w_main  = in_data;
        end
        ONE: if (w_acc & w_dq) w_main = in_data;
        else if (w_acc) begin
          w_state = TWO;
          w_skid  = in_data;
        end else if (w_dq) begin
          w_state = EMPTY;
          w_main  = BUBBLE;
        end
        TWO: if (w_dq) begin
          w_state = ONE;
          w_main  = r_skid;
        end
        default: begin
          w_state = EMPTY;
          w_main  = BUBBLE;
        end
      endcase
    end
  end
  always_ff @(posedge clk) begin
    r_state <= w_state;
    r_main  <= w_main;
    r_skid  <= w_skid;
  end
endmodule

// File: tb/tb_pip_skid_reg.sv
// tb_pip_skid_reg: directed and randomized checks of pip_skid_reg at WIDTH=8 and WIDTH=1
module tb_pip_skid_reg;
  localparam logic [7:0] B8 = 8'hEE;
  logic       clk = 0, reset = 1, flush = 0;
  logic       in_valid = 0, in_ready, out_valid, out_ready = 0;
  logic [7:0] in_data = 0, out_data;
  logic [1:0] occupancy;
  logic       v1 = 0, rdy1, ov1, or1 = 0, d1 = 0, od1;
  logic [1:0] occ1;
  int         errors = 0, checks = 0;

  always #5 clk = ~clk;

  pip_skid_reg #(.WIDTH(8), .BUBBLE(B8)) dut8 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy)
  );

  pip_skid_reg #(.WIDTH(1)) dut1 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(v1), .in_ready(rdy1), .in_data(d1),
    .out_valid(ov1), .out_ready(or1), .out_data(od1),
    .occupancy(occ1)
  );

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1; in_valid = 1; in_data = 8'h55; out_ready = 1; v1 = 1; d1 = 1; or1 = 1;
    step; step;
    checks++;
    if ({out_valid, out_data, occupancy, in_ready} !== {1'b0, B8, 2'd0, 1'b1}) begin
      errors++; $display("FAIL reset8: got %h exp %h", {out_valid, out_data, occupancy, in_ready}, {1'b0, B8, 2'd0, 1'b1});
    end
    checks++;
    if ({ov1, od1, occ1, rdy1} !== {1'b0, 1'b0, 2'd0, 1'b1}) begin
      errors++; $display("FAIL reset1: got %b exp %b", {ov1, od1, occ1, rdy1}, 5'b00001);
    end
    reset = 0; in_valid = 0; v1 = 0; or1 = 0;
    step;
    checks++;
    if ({out_valid, out_data, occupancy, in_ready} !== {1'b0, B8, 2'd0, 1'b1}) begin
      errors++; $display("FAIL idle: got %h exp %h", {out_valid, out_data, occupancy, in_ready}, {1'b0, B8, 2'd0, 1'b1});
    end
  endtask

  task automatic test_stream;
    logic [7:0] d[3] = '{8'h11, 8'h22, 8'h33};
    out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; in_data = d[i];
      step;
      checks++;
      if ({out_valid, out_data, occupancy, in_ready} !== {1'b1, d[i], 2'd1, 1'b1}) begin
        errors++; $display("FAIL stream%0d: got %h exp %h", i, {out_valid, out_data, occupancy, in_ready}, {1'b1, d[i], 2'd1, 1'b1});
      end
    end
    in_valid = 0;
    step;
    checks++;
    if ({out_valid, out_data, occupancy, in_ready} !== {1'b0, B8, 2'd0, 1'b1}) begin
      errors++; $display("FAIL stream_drain: got %h exp %h", {out_valid, out_data, occupancy, in_ready}, {1'b0, B8, 2'd0, 1'b1});
    end
  endtask

  task automatic test_stall;
    out_ready = 0; in_valid = 1; in_data = 8'hA0;
    step;
    checks++;
    if ({out_valid, out_data, occupancy, in_ready} !== {1'b1, 8'hA0, 2'd1, 1'b1}) begin
      errors++; $display("FAIL stall_one: got %h exp %h", {out_valid, out_data, occupancy, in_ready}, {1'b1, 8'hA0, 2'd1, 1'b1});
    end
    in_data = 8'hA1;
    step;
    in_data = 8'hA2;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({out_valid, out_data, occupancy, in_ready} !== {1'b1, 8'hA0, 2'd2, 1'b0}) begin
        errors++; $display("FAIL stall_hold%0d: got %h exp %h", i, {out_valid, out_data, occupancy, in_ready}, {1'b1, 8'hA0, 2'd2, 1'b0});
      end
      step;
    end
    out_ready = 1;
    step;
    checks++;
    if ({out_valid, out_data, occupancy, in_ready} !== {1'b1, 8'hA1, 2'd1, 1'b1}) begin
      errors++; $display("FAIL stall_rel_a1: got %h exp %h", {out_valid, out_data, occupancy, in_ready}, {1'b1, 8'hA1, 2'd1, 1'b1});
    end
    step;
    checks++;
    if ({out_valid, out_data, occupancy, in_ready} !== {1'b1, 8'hA2, 2'd1, 1'b1}) begin
      errors++; $display("FAIL stall_rel_a2: got %h exp %h", {out_valid, out_data, occupancy, in_ready}, {1'b1, 8'hA2, 2'd1, 1'b1});
    end
    in_valid = 0;
    step;
    checks++;
    if ({out_valid, out_data, occupancy, in_ready} !== {1'b0, B8, 2'd0, 1'b1}) begin
      errors++; $display("FAIL stall_drain: got %h exp %h", {out_valid, out_data, occupancy, in_ready}, {1'b0, B8, 2'd0, 1'b1});
    end
  endtask

  task automatic test_flush;
    out_ready = 0; in_valid = 1; in_data = 8'h05;
    step;
    in_data = 8'h06;
    step;
    checks++;
    if ({out_valid, out_data, occupancy, in_ready} !== {1'b1, 8'h05, 2'd2, 1'b0}) begin
      errors++; $display("FAIL flush_fill: got %h exp %h", {out_valid, out_data, occupancy, in_ready}, {1'b1, 8'h05, 2'd2, 1'b0});
    end
    flush = 1; in_data = 8'h07;
    step;
    flush = 0; in_valid = 0;
    checks++;
    if ({out_valid, out_data, occupancy, in_ready} !== {1'b0, B8, 2'd0, 1'b1}) begin
      errors++; $display("FAIL flush_empty: got %h exp %h", {out_valid, out_data, occupancy, in_ready}, {1'b0, B8, 2'd0, 1'b1});
    end
    out_ready = 1;
    step; step;
    checks++;
    if ({out_valid, out_data, occupancy, in_ready} !== {1'b0, B8, 2'd0, 1'b1}) begin
      errors++; $display("FAIL flush_no_leak: got %h exp %h", {out_valid, out_data, occupancy, in_ready}, {1'b0, B8, 2'd0, 1'b1});
    end
  endtask

  task automatic test_reset_flush;
    out_ready = 0; in_valid = 1; in_data = 8'h08;
    step;
    checks++;
    if ({out_valid, out_data, occupancy, in_ready} !== {1'b1, 8'h08, 2'd1, 1'b1}) begin
      errors++; $display("FAIL rf_one: got %h exp %h", {out_valid, out_data, occupancy, in_ready}, {1'b1, 8'h08, 2'd1, 1'b1});
    end
    reset = 1; flush = 1; in_data = 8'h0A;
    step;
    reset = 0; flush = 0; in_valid = 0;
    checks++;
    if ({out_valid, out_data, occupancy, in_ready} !== {1'b0, B8, 2'd0, 1'b1}) begin
      errors++; $display("FAIL rf_empty: got %h exp %h", {out_valid, out_data, occupancy, in_ready}, {1'b0, B8, 2'd0, 1'b1});
    end
    checks++;
    if (dut8.r_skid !== B8) begin
      errors++; $display("FAIL rf_skid: got %h exp %h", dut8.r_skid, B8);
    end
    in_valid = 1; in_data = 8'h09; out_ready = 1;
    step;
    in_valid = 0;
    checks++;
    if ({out_valid, out_data, occupancy, in_ready} !== {1'b1, 8'h09, 2'd1, 1'b1}) begin
      errors++; $display("FAIL rf_beat: got %h exp %h", {out_valid, out_data, occupancy, in_ready}, {1'b1, 8'h09, 2'd1, 1'b1});
    end
    step;
    checks++;
    if ({out_valid, out_data, occupancy, in_ready} !== {1'b0, B8, 2'd0, 1'b1}) begin
      errors++; $display("FAIL rf_alone: got %h exp %h", {out_valid, out_data, occupancy, in_ready}, {1'b0, B8, 2'd0, 1'b1});
    end
  endtask

  task automatic test_random;
    logic [7:0] q8[$];
    logic       q1[$];
    logic       pv8 = 0, pr8 = 0, pv1 = 0, pr1 = 0, pf = 0, pd1 = 0;
    logic [7:0] pd8 = 0;
    for (int i = 0; i < 10000; i++) begin
      checks++;
      if (out_valid !== (q8.size() != 0) || occupancy !== 2'(q8.size()) || in_ready !== (q8.size() < 2) ||
          (!out_valid && out_data !== B8) || (!pf && pv8 && !pr8 && out_data !== pd8)) begin
        errors++;
        $display("FAIL rand8 cyc %0d: ov=%b od=%h occ=%0d ir=%b exp occ=%0d prev_od=%h", i, out_valid, out_data, occupancy, in_ready, q8.size(), pd8);
      end
      checks++;
      if (ov1 !== (q1.size() != 0) || occ1 !== 2'(q1.size()) || rdy1 !== (q1.size() < 2) ||
          (!ov1 && od1 !== 1'b0) || (!pf && pv1 && !pr1 && od1 !== pd1)) begin
        errors++;
        $display("FAIL rand1 cyc %0d: ov=%b od=%b occ=%0d ir=%b exp occ=%0d prev_od=%b", i, ov1, od1, occ1, rdy1, q1.size(), pd1);
      end
      flush = $urandom_range(0, 99) == 0;
      in_valid = $urandom_range(0, 3) != 0; in_data = 8'($urandom); out_ready = $urandom_range(0, 2) != 0;
      v1 = $urandom_range(0, 2) != 0; d1 = 1'($urandom); or1 = $urandom_range(0, 3) != 0;
      if (out_valid && out_ready) begin
        checks++;
        if (q8.size() == 0 || out_data !== q8[0]) begin
          errors++; $display("FAIL rand8_order cyc %0d: got %h exp %h", i, out_data, q8.size() ? q8[0] : B8);
        end
        if (q8.size() != 0) void'(q8.pop_front());
      end
      if (ov1 && or1) begin
        checks++;
        if (q1.size() == 0 || od1 !== q1[0]) begin
          errors++; $display("FAIL rand1_order cyc %0d: got %b exp %b", i, od1, q1.size() ? q1[0] : 1'b0);
        end
        if (q1.size() != 0) void'(q1.pop_front());
      end
      if (flush) begin
        q8.delete(); q1.delete();
      end else begin
        if (in_valid && in_ready) q8.push_back(in_data);
        if (v1 && rdy1) q1.push_back(d1);
      end
      pv8 = out_valid; pr8 = out_ready; pd8 = out_data;
      pv1 = ov1; pr1 = or1; pd1 = od1; pf = flush;
      step;
    end
    flush = 0; in_valid = 0; v1 = 0;
  endtask

  initial begin
    test_reset;
    test_stream;
    test_stall;
    test_flush;
    test_reset_flush;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
